// File: rtl/wb_stage_pkg.sv
// Shared types for the writeback stage: FIFO entry layout, load sizes,
// FIFO occupancy states and the "does this entry write the RF" helper.
// Entry fields are sized for the widest supported configuration
// (64-bit data, up to 8-bit register address); narrower instances
// zero-extend into them.
package wb_stage_pkg;

    localparam int unsigned WB_DATA_MAX = 64;
    localparam int unsigned WB_RD_MAX   = 8;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    typedef struct packed {
        logic [WB_RD_MAX-1:0]   rd;
        logic                   rd_wen;
        logic [WB_DATA_MAX-1:0] data;
        logic                   is_load;
        ld_size_e               ld_size;
        logic                   ld_unsigned;
        logic [2:0]             ld_off;
        logic                   exc;
    } wb_entry_t;

    // An entry writes the register file only when it asks to, did not
    // trap, and does not target the hard-wired zero register.
    function automatic logic entry_writes(input wb_entry_t e);
        return e.rd_wen && !e.exc && (e.rd != {WB_RD_MAX{1'b0}});
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load formatter: shifts the raw word down by the byte
// offset, keeps 8/16/32/64 bits and sign- or zero-extends to XLEN.
// For XLEN=32 a dword request is treated as a word and the offset wraps
// modulo 4.
module wb_load_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [2:0]      off_i,
    output logic [XLEN-1:0] data_o
);

    logic [2:0]      off_eff_s;
    logic [5:0]      shamt_s;
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] mask_s;
    logic            sign_s;
    ld_size_e        size_eff_s;

    // Offset/size normalisation for the configured width, then shift.
    always_comb begin
        if (XLEN == 32) begin
            off_eff_s  = {1'b0, off_i[1:0]};
            size_eff_s = (ld_size_e'(size_i) == LD_D) ? LD_W : ld_size_e'(size_i);
        end else begin
            off_eff_s  = off_i;
            size_eff_s = ld_size_e'(size_i);
        end
        shamt_s   = {off_eff_s, 3'b000};
        shifted_s = data_i >> shamt_s;
    end

    // Select the kept bits and the extension bit, then merge the fill.
    always_comb begin
        case (size_eff_s)
            LD_B: begin
                mask_s = XLEN'(8'hFF);
                sign_s = shifted_s[7];
            end
            LD_H: begin
                mask_s = XLEN'(16'hFFFF);
                sign_s = shifted_s[15];
            end
            LD_W: begin
                mask_s = XLEN'(32'hFFFF_FFFF);
                sign_s = shifted_s[31];
            end
            default: begin
                mask_s = {XLEN{1'b1}};
                sign_s = shifted_s[XLEN-1];
            end
        endcase
        if (sign_s && !unsigned_i) begin
            data_o = (shifted_s & mask_s) | ~mask_s;
        end else begin
            data_o = shifted_s & mask_s;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: 2-entry FIFO from the memory stage, load formatting on
// the head entry, single register-file write port, retire counter and
// trap pulse for excepting instructions.
// Optional: define WB_FWD_EN to add the execute-stage bypass outputs
// fwd_valid/fwd_rd/fwd_data and the fwd_pend pending-write flag.
module writeback_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RF_AW = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RF_AW-1:0] in_rd,
    input  logic             in_rd_wen,
    input  logic [XLEN-1:0]  in_data,
    input  logic             in_is_load,
    input  logic [1:0]       in_ld_size,
    input  logic             in_ld_unsigned,
    input  logic [2:0]       in_ld_off,
    input  logic             in_exc,
    output logic             rf_wen,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    input  logic             rf_ready,
    output logic             trap_o,
`ifdef WB_FWD_EN
    output logic             fwd_valid,
    output logic [RF_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             fwd_pend,
`endif
    output logic [CNT_W-1:0] retire_cnt
);

    fifo_state_e      state_q, state_d;
    wb_entry_t        slot0_q, slot0_d;   // head
    wb_entry_t        slot1_q, slot1_d;   // second
    logic [CNT_W-1:0] cnt_q, cnt_d;

    wb_entry_t        new_s;
    logic             push_s;
    logic             pop_s;
    logic             head_valid_s;
    logic             head_writes_s;
    logic [XLEN-1:0]  head_raw_s;
    logic [XLEN-1:0]  head_aligned_s;
    logic [XLEN-1:0]  head_fmt_s;

    // Pack the incoming beat into the shared entry layout.
    always_comb begin
        new_s             = '0;
        new_s.rd          = WB_RD_MAX'(in_rd);
        new_s.rd_wen      = in_rd_wen;
        new_s.data        = WB_DATA_MAX'(in_data);
        new_s.is_load     = in_is_load;
        new_s.ld_size     = ld_size_e'(in_ld_size);
        new_s.ld_unsigned = in_ld_unsigned;
        new_s.ld_off      = in_ld_off;
        new_s.exc         = in_exc;
    end

    // in_ready depends on registered occupancy only; no path from rf_ready.
    assign in_ready      = (state_q != FULL);
    assign push_s        = in_valid && in_ready;
    assign head_valid_s  = (state_q != EMPTY);
    assign head_writes_s = entry_writes(slot0_q);
    // Non-writing heads (x0, no rd_wen, exception) never wait on the port.
    assign pop_s         = head_valid_s && (rf_ready || !head_writes_s);
    assign head_raw_s    = slot0_q.data[XLEN-1:0];

    wb_load_align #(
        .XLEN(XLEN)
    ) u_align (
        .data_i     (head_raw_s),
        .size_i     (slot0_q.ld_size),
        .unsigned_i (slot0_q.ld_unsigned),
        .off_i      (slot0_q.ld_off),
        .data_o     (head_aligned_s)
    );

    // Head-driven register-file port; address/data forced to 0 when idle.
    always_comb begin
        head_fmt_s = slot0_q.is_load ? head_aligned_s : head_raw_s;
        rf_wen     = head_valid_s && head_writes_s;
        if (rf_wen) begin
            rf_waddr = slot0_q.rd[RF_AW-1:0];
            rf_wdata = head_fmt_s;
        end else begin
            rf_waddr = {RF_AW{1'b0}};
            rf_wdata = {XLEN{1'b0}};
        end
        trap_o = pop_s && slot0_q.exc;
    end

    // FIFO occupancy and slot movement; no bypass around a stalled head.
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (state_q)
            EMPTY: begin
                if (push_s) begin
                    slot0_d = new_s;
                    state_d = ONE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    slot0_d = new_s;
                    state_d = ONE;
                end else if (push_s) begin
                    slot1_d = new_s;
                    state_d = FULL;
                end else if (pop_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = ONE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    slot0_d = slot1_q;
                    state_d = ONE;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Retire counter: every non-excepting pop counts, wrapping naturally.
    always_comb begin
        if (pop_s && !slot0_q.exc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset discards any entries in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;

`ifdef WB_FWD_EN
    assign fwd_valid = rf_wen;
    assign fwd_rd    = rf_waddr;
    assign fwd_data  = rf_wdata;
    assign fwd_pend  = (head_valid_s && entry_writes(slot0_q)) ||
                       ((state_q == FULL) && entry_writes(slot1_q));
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Sits directly downstream of the memory stage and consumes the writeback-input transaction stream that the WriteBack_in agent drives and monitors.
- Buffers results in a 2-entry FIFO, then formats load data (size, sign and byte offset).
- Drives the single register-file write port and a retire counter.
- Suppresses writes for excepting instructions and pulses a trap indication instead.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- RF_AW, 5, register address width.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  stage clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  memory-stage result valid
- in_ready  out  1  stage can accept
- in_rd  in  RF_AW  destination register
- in_rd_wen  in  1  instruction writes rd
- in_data  in  XLEN  ALU result or raw load word
- in_is_load  in  1  in_data is load data needing formatting
- in_ld_size  in  2  0=byte, 1=half, 2=word, 3=dword (XLEN=64 only)
- in_ld_unsigned  in  1  zero-extend instead of sign-extend
- in_ld_off  in  3  byte offset of the access within in_data
- in_exc  in  1  instruction raised an exception
- rf_wen  out  1  register-file write enable
- rf_waddr  out  RF_AW  write address
- rf_wdata  out  XLEN  write data
- rf_ready  in  1  write port available this cycle
- trap_o  out  1  one-cycle pulse: excepting instruction retired
- retire_cnt  out  CNT_W  instructions retired

Behaviour:
- Reset, asynchronous, rst_n low:
  - FIFO emptied.
  - in_ready=1; rf_wen=0, rf_waddr=0, rf_wdata=0; trap_o=0; retire_cnt=0.
  - Entries in flight are discarded; nothing is written.
- Enqueue: a beat is accepted when in_valid && in_ready.
- in_ready = !full. It is registered-state only, with no combinational path from rf_ready.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full keeps the count unchanged.
- Latency: a beat accepted in cycle N is at the head in N+1. rf_* is valid combinationally from the head in N+1.
- Head outputs:
  - rf_wen = head_valid && rd_wen && !exc && rd!=0.
  - rf_waddr = head rd; rf_wdata = formatted data.
  - When rf_wen=0, rf_waddr and rf_wdata hold 0.
- Pop condition for a head entry:
  - Pops when rf_ready=1, or when the entry does not write (rd_wen=0, rd=0, or exc), regardless of rf_ready.
  - An x0 write is dropped but still retires.
- Retire:
  - Each pop of a non-excepting entry increments retire_cnt, wrapping modulo 2^CNT_W. All-ones + 1 = 0.
  - Each pop of an excepting entry pulses trap_o for exactly that cycle and does not increment retire_cnt.
- Load format, when is_load=1:
  - Shift in_data right by 8*ld_off.
  - Take the low 8/16/32/64 bits for size 0/1/2/3.
  - Sign-extend to XLEN, or zero-extend when ld_unsigned=1.
  - Size 3 with XLEN=32 behaves as size 2.
  - ld_off is used modulo XLEN/8.
- Non-load data passes through unchanged.
- FIFO states: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - push only: EMPTY->ONE, ONE->FULL.
  - pop only: the reverse.
  - push and pop: state held.
- Back-pressure ordering: FIFO order is preserved; there is no bypass around a stalled head.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined adds outputs fwd_valid (1), fwd_rd (RF_AW) and fwd_data (XLEN). They are combinationally equal to rf_wen, rf_waddr and rf_wdata, for execute-stage bypass.
- The macro also adds fwd_pend (1): high when any FIFO entry, head or second, has a pending write to a nonzero rd.
- Undefined: none of these ports exist, and behaviour is otherwise identical.

Decomposition:
- Package wb_stage_pkg holds:
  - typedef wb_entry_t {rd, rd_wen, data, is_load, ld_size, ld_unsigned, ld_off, exc};
  - enum ld_size_e {LD_B, LD_H, LD_W, LD_D};
  - enum fifo_state_e {EMPTY, ONE, FULL}.
- One combinational sub-module, wb_load_align (data, size, unsigned, off -> formatted), instantiated on the head entry.

Test Plan:
- Byte load: data=0x8070_6050, size=0, off=3, signed, rd=5, rf_ready=1 -> next cycle rf_wen=1, waddr=5, wdata=0xFFFF_FF80, retire_cnt=1.
- Half load, unsigned: same data, size=1, off=2, unsigned -> wdata=0x0000_8070.
- Back-pressure: 3 back-to-back writes with rf_ready=0 -> in_ready drops after 2 accepts. Releasing rf_ready retires them in order over 2 cycles, then the third. No loss.
- Exception: exc=1, rd=7 -> rf_wen stays 0, trap_o=1 for one cycle, retire_cnt unchanged.
- x0 write and wrap: rd=0 with rf_ready=0 -> retires without a write. A retire with retire_cnt preloaded to 0xFFFF_FFFF -> 0.
- Reset mid-operation: FIFO full, rst_n low -> rf_wen=0, in_ready=1, count 0 on the next edge. With WB_FWD_EN, fwd_pend=0.
